// File: rtl/min_reduce_pipe.sv
// min_reduce_pipe: pipelined unsigned min/max reduction over N lanes and multi-beat groups.
// Defining MIN_REDUCE_ARGMIN_EN adds the out_idx port (lane index of the winning operand).
module min_reduce_pipe #(
   parameter int W     = 16,
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*W-1:0]   in_data,
   input  logic             in_last,
   input  logic             op_max,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic [CNT_W-1:0] out_count
`ifdef MIN_REDUCE_ARGMIN_EN
   ,
   output logic [$clog2(N)-1:0] out_idx
`endif
);

   localparam int L     = $clog2(N);
   localparam int NODES = 2 * N - 1;
   localparam int TOP   = NODES - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
`ifdef MIN_REDUCE_ARGMIN_EN
   localparam int IW = L;
`endif

   // Tree nodes are packed level by level: level 0 holds the N input lanes, level L the single root.
   function automatic int lvl_off(input int k);
      return 2 * N - 2 * (N >> k);
   endfunction

   // A candidate replaces the incumbent only when strictly better, so ties keep the earlier operand.
   function automatic logic better(input logic [W-1:0] cand, input logic [W-1:0] cur,
                                   input logic use_max);
      return use_max ? (cand > cur) : (cand < cur);
   endfunction

   logic             stall;
   logic             at_start;
   logic             grp_op;
   logic             beat_op;

   logic [L:0]       lvl_valid;
   logic [L:0]       lvl_last;
   logic [L:0]       lvl_first;
   logic [L:0]       lvl_op;
   logic [W-1:0]     node_data [NODES];

   logic [W-1:0]     acc_data;
   logic [CNT_W-1:0] acc_count;
   logic [W-1:0]     comb_data;
   logic [CNT_W-1:0] comb_count;

`ifdef MIN_REDUCE_ARGMIN_EN
   logic [IW-1:0]    node_idx [NODES];
   logic [IW-1:0]    acc_idx;
   logic [IW-1:0]    comb_idx;
`endif

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign beat_op  = at_start ? op_max : grp_op;

   // Group framing: the operation is captured on the first accepted beat and held for the group.
   always_ff @(posedge clk) begin
      if (rst) begin
         at_start <= 1'b1;
         grp_op   <= 1'b0;
      end else if (in_valid && in_ready) begin
         at_start <= in_last;
         if (at_start) begin
            grp_op <= op_max;
         end
      end
   end

   // Input register plus L comparator levels; beat flags travel alongside their data.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_valid <= '0;
         lvl_last  <= '0;
         lvl_first <= '0;
         lvl_op    <= '0;
         for (int n = 0; n < NODES; n++) begin
            node_data[n] <= '0;
`ifdef MIN_REDUCE_ARGMIN_EN
            node_idx[n]  <= '0;
`endif
         end
      end else if (!stall) begin
         lvl_valid <= {lvl_valid[L-1:0], in_valid};
         lvl_last  <= {lvl_last[L-1:0], in_last};
         lvl_first <= {lvl_first[L-1:0], at_start};
         lvl_op    <= {lvl_op[L-1:0], beat_op};
         for (int j = 0; j < N; j++) begin
            node_data[j] <= in_data[j*W +: W];
`ifdef MIN_REDUCE_ARGMIN_EN
            node_idx[j]  <= IW'(j);
`endif
         end
         for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < (N >> k); j++) begin
               if (better(node_data[lvl_off(k-1) + 2*j + 1], node_data[lvl_off(k-1) + 2*j],
                          lvl_op[k-1])) begin
                  node_data[lvl_off(k) + j] <= node_data[lvl_off(k-1) + 2*j + 1];
`ifdef MIN_REDUCE_ARGMIN_EN
                  node_idx[lvl_off(k) + j]  <= node_idx[lvl_off(k-1) + 2*j + 1];
`endif
               end else begin
                  node_data[lvl_off(k) + j] <= node_data[lvl_off(k-1) + 2*j];
`ifdef MIN_REDUCE_ARGMIN_EN
                  node_idx[lvl_off(k) + j]  <= node_idx[lvl_off(k-1) + 2*j];
`endif
               end
            end
         end
      end
   end

   // First beat of a group loads straight from the tree root; later beats merge with the accumulator.
   always_comb begin
      comb_data  = node_data[TOP];
      comb_count = CNT_W'(1);
`ifdef MIN_REDUCE_ARGMIN_EN
      comb_idx   = node_idx[TOP];
`endif
      if (!lvl_first[L]) begin
         comb_count = (acc_count == CNT_MAX) ? CNT_MAX : acc_count + 1'b1;
         if (!better(node_data[TOP], acc_data, lvl_op[L])) begin
            comb_data = acc_data;
`ifdef MIN_REDUCE_ARGMIN_EN
            comb_idx  = acc_idx;
`endif
         end
      end
   end

   // Accumulator and result register share one stage; a last beat publishes the merged value.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_data  <= '0;
         acc_count <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
`ifdef MIN_REDUCE_ARGMIN_EN
         acc_idx   <= '0;
         out_idx   <= '0;
`endif
      end else if (!stall) begin
         out_valid <= lvl_valid[L] && lvl_last[L];
         if (lvl_valid[L]) begin
            acc_data  <= comb_data;
            acc_count <= comb_count;
`ifdef MIN_REDUCE_ARGMIN_EN
            acc_idx   <= comb_idx;
`endif
            if (lvl_last[L]) begin
               out_data  <= comb_data;
               out_count <= comb_count;
`ifdef MIN_REDUCE_ARGMIN_EN
               out_idx   <= comb_idx;
`endif
            end
         end
      end
   end

endmodule
